// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage: decodes instruction format and XLEN-wide immediate,
// registers the result behind a valid/ready handshake with a 2-entry skid buffer.
module imm_decode_stage #(
    parameter int unsigned XLEN        = 32,
    parameter bit          ENABLE_ZIMM = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned IMM64_W = 64;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    imm;
        fmt_e               fmt;
        logic               illegal;
    } entry_t;

    entry_t               dec_c;
    logic [IMM64_W-1:0]   imm64_c;
    fmt_e                 fmt_c;
    logic                 illegal_c;
    logic                 sgn_c;

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept_c;
    logic   drain_c;

    // Combinational format/immediate decode of the incoming word
    always_comb begin
        imm64_c   = '0;
        fmt_c     = FMT_NONE;
        illegal_c = 1'b0;
        sgn_c     = in_instr[31];
        if (in_instr[1:0] != 2'b11) begin
            illegal_c = 1'b1;
        end else begin
            unique case (in_instr[6:0])
                OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                    fmt_c   = FMT_I;
                    imm64_c = {{52{sgn_c}}, in_instr[31:20]};
                end
                OPC_OP_IMM32: begin
                    if (XLEN == 64) begin
                        fmt_c   = FMT_I;
                        imm64_c = {{52{sgn_c}}, in_instr[31:20]};
                    end else begin
                        illegal_c = 1'b1;
                    end
                end
                OPC_STORE: begin
                    fmt_c   = FMT_S;
                    imm64_c = {{52{sgn_c}}, in_instr[31:25], in_instr[11:7]};
                end
                OPC_BRANCH: begin
                    fmt_c   = FMT_B;
                    imm64_c = {{52{sgn_c}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    fmt_c   = FMT_U;
                    imm64_c = {{32{sgn_c}}, in_instr[31:12], 12'b0};
                end
                OPC_JAL: begin
                    fmt_c   = FMT_J;
                    imm64_c = {{44{sgn_c}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
                end
                OPC_SYSTEM: begin
                    // CSR-immediate forms carry a 5-bit unsigned zimm in the rs1 field
                    if (ENABLE_ZIMM && in_instr[14]) begin
                        fmt_c   = FMT_Z;
                        imm64_c = {59'b0, in_instr[19:15]};
                    end
                end
                OPC_OP, OPC_FENCE: begin
                    fmt_c = FMT_NONE;
                end
                default: begin
                    illegal_c = 1'b1;
                end
            endcase
        end
        dec_c.instr   = in_instr;
        dec_c.imm     = XLEN'(imm64_c);
        dec_c.fmt     = fmt_c;
        dec_c.illegal = illegal_c;
    end

    assign accept_c = in_valid && in_ready_q;
    assign drain_c  = out_valid_q && out_ready;

    // Output/skid buffer control; skid always drains into OUT first to keep FIFO order
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain_c && skid_valid_q) begin
            out_d        = skid_q;
            skid_valid_d = accept_c;
            if (accept_c) begin
                skid_d = dec_c;
            end
        end else if (accept_c && (!out_valid_q || drain_c)) begin
            out_d       = dec_c;
            out_valid_d = 1'b1;
        end else if (accept_c) begin
            skid_d       = dec_c;
            skid_valid_d = 1'b1;
        end else if (drain_c) begin
            out_valid_d = 1'b0;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_instr   = out_q.instr;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances share stimulus and a
// scoreboard queue of accepted instructions, decoded by a reference model at drain time.
module tb_imm_decode_stage;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        ill;
    } dec_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_ill32;
    logic [31:0] out_instr32, out_imm32;
    logic [2:0]  out_fmt32;
    logic        in_ready64, out_valid64, out_ill64;
    logic [31:0] out_instr64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          chk_en   = 0;
    logic [31:0] q[$];

    imm_decode_stage #(.XLEN(32), .ENABLE_ZIMM(1'b1)) d32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
        .out_valid(out_valid32), .out_ready(out_ready), .out_instr(out_instr32),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_ill32)
    );

    imm_decode_stage #(.XLEN(64), .ENABLE_ZIMM(1'b1)) d64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
        .out_valid(out_valid64), .out_ready(out_ready), .out_instr(out_instr64),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_ill64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Reference decoder, written from the opcode table
    function automatic dec_t model(input logic [31:0] ins, input bit x64);
        dec_t d;
        logic s;
        s = ins[31];
        d = '0;
        if (ins[1:0] != 2'b11) d.ill = 1'b1;
        else begin
            case (ins[6:0])
                7'b0000011, 7'b0010011, 7'b1100111: begin d.fmt = 3'd1; d.imm = {{52{s}}, ins[31:20]}; end
                7'b0011011: begin
                    if (x64) begin d.fmt = 3'd1; d.imm = {{52{s}}, ins[31:20]}; end
                    else d.ill = 1'b1;
                end
                7'b0100011: begin d.fmt = 3'd2; d.imm = {{52{s}}, ins[31:25], ins[11:7]}; end
                7'b1100011: begin d.fmt = 3'd3; d.imm = {{52{s}}, ins[7], ins[30:25], ins[11:8], 1'b0}; end
                7'b0110111, 7'b0010111: begin d.fmt = 3'd4; d.imm = {{32{s}}, ins[31:12], 12'b0}; end
                7'b1101111: begin d.fmt = 3'd5; d.imm = {{44{s}}, ins[19:12], ins[20], ins[30:21], 1'b0}; end
                7'b1110011: if (ins[14]) begin d.fmt = 3'd6; d.imm = {59'b0, ins[19:15]}; end
                7'b0110011, 7'b0001111: d.fmt = 3'd0;
                default: d.ill = 1'b1;
            endcase
        end
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  tab[13] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
                                 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0110011,
                                 7'b0001111, 7'b0011011, 7'b1111111};
        logic [31:0] r;
        int          pick;
        r    = $urandom;
        pick = $urandom_range(0, 13);
        if (pick < 13) r[6:0] = tab[pick];
        return r;
    endfunction

    // Scoreboard: sampled mid-cycle, mirrors the handshakes at the next rising edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid32", 64'(out_valid32), 64'(q.size() != 0));
            check("out_valid64", 64'(out_valid64), 64'(q.size() != 0));
            check("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
            check("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
            if (flush) q.delete();
            else begin
                if (out_valid32 && out_ready && q.size() != 0) begin
                    logic [31:0] e;
                    dec_t m32, m64;
                    e   = q.pop_front();
                    m32 = model(e, 1'b0);
                    m64 = model(e, 1'b1);
                    check("sb_instr32", 64'(out_instr32), 64'(e));
                    check("sb_imm32", 64'(out_imm32), 64'(m32.imm[31:0]));
                    check("sb_fmt32", 64'(out_fmt32), 64'(m32.fmt));
                    check("sb_ill32", 64'(out_ill32), 64'(m32.ill));
                    check("sb_instr64", 64'(out_instr64), 64'(e));
                    check("sb_imm64", out_imm64, m64.imm);
                    check("sb_fmt64", 64'(out_fmt64), 64'(m64.fmt));
                    check("sb_ill64", 64'(out_ill64), 64'(m64.ill));
                end
                if (in_valid && in_ready32) q.push_back(in_instr);
            end
        end
    end

    task automatic send(input logic [31:0] ins);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_instr = ins;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready32;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 64'(0), 64'(1));
    endtask

    // Known-answer: one instruction through an idle stage, compared to literal values
    task automatic kat(input string tag, input logic [31:0] ins, input logic [2:0] efmt,
                       input logic [63:0] eimm, input logic eill);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = ins;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_valid"}, 64'(out_valid32), 64'(1));
        check({tag, "_fmt32"}, 64'(out_fmt32), 64'(efmt));
        check({tag, "_imm32"}, 64'(out_imm32), 64'(eimm[31:0]));
        check({tag, "_ill32"}, 64'(out_ill32), 64'(eill));
        check({tag, "_fmt64"}, 64'(out_fmt64), 64'(efmt));
        check({tag, "_imm64"}, out_imm64, eimm);
        check({tag, "_ill64"}, 64'(out_ill64), 64'(eill));
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 64'(out_valid32 | out_valid64), 64'(0));
        check({tag, "_ready"}, 64'(in_ready32 | in_ready64), 64'(0));
        check({tag, "_instr"}, 64'(out_instr32 | out_instr64), 64'(0));
        check({tag, "_imm"}, 64'(out_imm32) | out_imm64, 64'(0));
        check({tag, "_fmt"}, 64'(out_fmt32 | out_fmt64), 64'(0));
        check({tag, "_ill"}, 64'(out_ill32 | out_ill64), 64'(0));
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        #3;
        check_zero("rst");
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_ready", 64'(in_ready32), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_ready", 64'(in_ready32 & in_ready64), 64'(1));
        chk_en = 1'b1;

        kat("addi", 32'hFFF0_0093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        kat("sw", 32'hFE11_2E23, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        kat("lui", 32'h1234_5037, 3'd4, 64'h0000_0000_1234_5000, 1'b0);
        kat("luineg", 32'h8000_00B7, 3'd4, 64'hFFFF_FFFF_8000_0000, 1'b0);
        kat("csrrwi", 32'h3008_D073, 3'd6, 64'h0000_0000_0000_0011, 1'b0);
        kat("illop", 32'h0000_007F, 3'd0, 64'h0, 1'b1);

        // Back-to-back stream, one per cycle
        out_ready = 1'b1;
        send(32'hFE11_2E23);
        send(32'h1234_5037);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Back-pressure: A in OUT, B in SKID, C stalled
        out_ready = 1'b0;
        send(32'h0010_0093);
        send(32'h0020_0113);
        in_valid = 1'b1;
        in_instr = 32'h0030_0193;
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_stall_ready", 64'(in_ready32 | in_ready64), 64'(0));
        end
        out_ready = 1'b1;
        send(32'h0030_0193);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Flush with both entries full and a stalled offer
        out_ready = 1'b0;
        send(32'h0040_0213);
        send(32'h0050_0293);
        in_valid = 1'b1;
        in_instr = 32'h0060_0313;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 64'(out_valid32 | out_valid64), 64'(0));
        check("flush_ready", 64'(in_ready32 & in_ready64), 64'(1));

        // Flush discarding an accept in the same cycle
        send(32'h0070_0393);
        in_valid = 1'b1;
        in_instr = 32'h0080_0413;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush2_valid", 64'(out_valid32), 64'(0));
        out_ready = 1'b1;
        send(32'h0090_0493);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Randomised traffic with back-pressure and occasional flush
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            @(posedge clk); #1;
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("drain_empty", 64'(q.size()), 64'(0));

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send(32'h00A0_0513);
        send(32'h00B0_0593);
        in_valid = 1'b0;
        @(posedge clk); #3;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_zero("midrst");
        q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        kat("postrst", 32'hFFF0_0093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("final_empty", 64'(q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised immediate-decode pipeline stage between fetch and the register-read/execute stage. Accepts one 32-bit instruction per cycle over a valid/ready handshake, and decodes the format and the sign- or zero-extended XLEN-wide immediate. Presents the instruction, immediate, format code and an illegal-opcode flag one cycle later. A 2-entry skid buffer gives full throughput under back-pressure; a flush input drops in-flight entries.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- ENABLE_ZIMM, 1: 1 = decode SYSTEM CSR-immediate forms as format Z; 0 = treat them as format NONE.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous; discards both buffered entries.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept; registered.
- in_instr  input  32  instruction word.
- out_valid  output  1  decoded entry valid.
- out_ready  input  1  downstream accepts.
- out_instr  output  32  instruction passed through.
- out_imm  output  XLEN  decoded immediate.
- out_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
- out_illegal  output  1  unrecognised opcode or instr[1:0] != 2'b11.

## Operation
- Decode is combinational on in_instr. Result is registered into the output register (OUT) or the skid register (SKID).
- Format and immediate by opcode. S = {XLEN sign-extension of instr[31]}.
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111: fmt I, imm = S, instr[31:20].
  - STORE 0100011: fmt S, imm = S, instr[31:25], instr[11:7].
  - BRANCH 1100011: fmt B, imm = S, instr[7], instr[30:25], instr[11:8], 0.
  - LUI 0110111, AUIPC 0010111: fmt U, imm = S above bit 31, instr[31:12], 12'b0. For XLEN=64, bits 63:32 copy instr[31].
  - JAL 1101111: fmt J, imm = S, instr[19:12], instr[20], instr[30:21], 0.
  - SYSTEM 1110011 with funct3[2]=1 and ENABLE_ZIMM=1: fmt Z, imm = zero-extended instr[19:15]. All other SYSTEM forms: fmt NONE, imm 0, legal.
  - OP 0110011, FENCE 0001111: fmt NONE, imm 0, legal.
  - OP-IMM-32 0011011: when XLEN=64, fmt I as OP-IMM; when XLEN=32, illegal.
  - Any other opcode, or instr[1:0] != 11: fmt NONE, imm 0, out_illegal=1. The entry still flows through the stage.
- Buffer control. An accept occurs when in_valid && in_ready. A drain occurs when out_valid && out_ready.
  - Accept, OUT empty or draining, SKID empty: load OUT.
  - Accept, OUT full and not draining: load SKID.
  - Drain with SKID full: SKID moves to OUT, SKID empties. An accept in the same cycle goes to SKID.
  - Order is strictly FIFO; no entry is duplicated or lost.
- in_ready next = !SKID_valid_next.
- flush: next cycle OUT_valid=0, SKID_valid=0, in_ready=1. Any accept in the flush cycle is discarded. Flush wins over simultaneous accept or drain.
- Data registers load only on accept or move. They hold their values when invalid.

## Timing
- Reset (rst_n low, async): out_valid=0, in_ready=0 while asserted, then 1 from the first clk edge after release. out_instr=0, out_imm=0, out_fmt=0, out_illegal=0. SKID cleared.
- Reset mid-operation drops all entries immediately.
- Latency: an instruction accepted at edge N appears at out_* after edge N, at the same cycle as the registered output.
- Throughput: 1 instruction/cycle while out_ready=1.
- Back-pressure: with out_ready=0, at most 2 entries are held. in_ready falls in the cycle after SKID fills. It rises in the cycle after SKID drains.
- out_* are stable while out_valid=1 and out_ready=0.
- No combinational path from out_ready to in_ready.

## Test plan
- 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, fmt 1, imm 0xFFFFFFFF, illegal 0.
- 0xFE112E23 (sw x1,-4(x2)), then 0x12345037 (lui) back-to-back -> fmt 2 with imm 0xFFFFFFFC, then fmt 4 with imm 0x12345000, on consecutive cycles.
- XLEN=64: 0x800000B7 -> imm 0xFFFFFFFF80000000. 0x3008D073 (csrrwi) -> fmt 6, imm 0x11. 0x0000007F -> illegal 1, fmt 0, imm 0.
- out_ready=0, three instructions A, B, C offered -> A held in OUT, B in SKID, in_ready=0 while C is stalled. Raise out_ready -> A, B, C emitted in order, one per cycle.
- flush asserted while OUT and SKID are full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed instructions never appear.
- rst_n pulsed low mid-stream -> out_valid=0 immediately and all outputs zero. After release the first accepted instruction decodes correctly.
